core_run_monitor: RTL and testbench
===================================

// Module: core_run_monitor
// PURPOSE
//   Synthesizable run controller / PC observer, the consuming end of MIPS_Core's clk/rst/PC interface.
//   Drives the core's reset, releases it for a bounded run and samples PC every cycle.
//   Ends the run on a halt loop (PC stuck), a misaligned PC, or a cycle budget timeout.
//   Reports cycle count, last PC and the end cause, for FPGA bring-up and self-checking benches.
// PARAMETERS
//   RST_CYCLES   2      cycles core_rst is held high after start (>=1)
//   MAX_CYCLES   50     run budget in RUN cycles before timeout (>=1, < 2**CNT_W)
//   HALT_REPEAT  4      consecutive repeated-PC compares that declare a halt (>=1)
//   CNT_W        16     width of cycle counter
// PORTS
//   clk            in   1      core clock, rising edge
//   rst            in   1      async active-high reset of this block
//   start          in   1      1-cycle pulse: begin a run (honoured in IDLE and DONE only)
//   pc_in          in   32     PC from MIPS_Core
//   core_rst       out  1      reset to MIPS_Core, registered
//   running        out  1      high while in RUN
//   done           out  1      high while in DONE
//   halt_detected  out  1      run ended on stuck PC
//   timeout        out  1      run ended on budget exhaustion
//   pc_err         out  1      run ended on pc_in[1:0] != 0
//   cycle_count    out  CNT_W  RUN cycles elapsed in current/last run
//   last_pc        out  32     most recent PC sampled in RUN
// BEHAVIOUR
//   rst (any time, incl. mid-run): state=IDLE, core_rst=1, running=done=0, all flags=0,
//     cycle_count=0, last_pc=0, internal same_cnt=0, pc_valid=0; takes effect immediately.
//   FSM: IDLE -> RESET_HOLD -> RUN -> DONE -> (start) RESET_HOLD.
//   IDLE: core_rst=1; start -> RESET_HOLD; clear hold counter.
//   RESET_HOLD: core_rst=1 for exactly RST_CYCLES clocks, counted from entry; then -> RUN.
//     On entry clear flags, cycle_count, last_pc, same_cnt, pc_valid.
//   RUN: core_rst=0; running=1. Per clock:
//     - cycle_count <= cycle_count+1.
//     - last_pc <= pc_in; pc_valid <= 1.
//     - same_cnt <= (pc_valid && pc_in==last_pc) ? same_cnt+1 : 0.
//   RUN end conditions, evaluated on the updated values, in priority order:
//     1. pc_err: pc_in[1:0]!=0.
//     2. halt_detected: same_cnt reaches HALT_REPEAT.
//     3. timeout: cycle_count reaches MAX_CYCLES.
//   On the first one true: set exactly that flag, go to DONE next edge.
//     If several are true in the same cycle, only the highest priority flag is set.
//   DONE: done=1; core_rst=1 (core held in reset); flags, cycle_count and last_pc frozen.
//   start in RESET_HOLD or RUN is ignored. start in DONE restarts via RESET_HOLD.
//   First RUN cycle: no compare (pc_valid=0), so a PC equal to reset value is not a repeat.
//   cycle_count never wraps within a run, since MAX_CYCLES < 2**CNT_W.
//   All outputs are registered; no combinational path from pc_in to any output.
// TESTING
//   1. Reset: rst=1, 3 clk -> core_rst=1, done=0, cycle_count=0, last_pc=0; release, no start -> stays IDLE.
//   2. Reset hold: start pulse -> core_rst high exactly 2 clk, then 0; running=1 on same edge.
//   3. Halt: pc_in 0,4,8,C,C,C,C,C -> halt_detected=1, done=1.
//      last_pc=0xC, cycle_count=8, core_rst=1; timeout=0.
//   4. Timeout: pc_in increments by 4 each clk -> timeout=1 at cycle_count=50, halt_detected=0.
//   5. Misalign: pc_in=0x00000006 on 3rd RUN cycle -> pc_err=1, cycle_count=3, last_pc=0x6.
//      Same cycle as halt -> pc_err only.
//   6. Async reset mid-run: rst pulse between edges at cycle_count=10 -> immediately IDLE, core_rst=1, count=0.
//      Restart from DONE via start clears flags.

Source files
------------

// File: rtl/core_run_monitor.sv
// core_run_monitor: drives MIPS_Core reset, runs it for a bounded time and watches PC
// for a halt loop, a misaligned fetch or budget exhaustion.
module core_run_monitor #(
    parameter int RST_CYCLES  = 2,
    parameter int MAX_CYCLES  = 50,
    parameter int HALT_REPEAT = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      pc_in,
    output logic             core_rst,
    output logic             running,
    output logic             done,
    output logic             halt_detected,
    output logic             timeout,
    output logic             pc_err,
    output logic [CNT_W-1:0] cycle_count,
    output logic [31:0]      last_pc
);
    localparam int HW = $clog2(RST_CYCLES + 1);
    localparam int SW = $clog2(HALT_REPEAT + 1);

    typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [HW-1:0]    hold_cnt;
    logic [SW-1:0]    same_cnt, same_n;
    logic [CNT_W-1:0] cnt_n;
    logic             pc_valid, err_c, halt_c, to_c, restart;

    // End conditions are judged on the values this RUN cycle is about to store.
    always_comb begin
        state_n = state;
        restart = 1'b0;
        cnt_n   = cycle_count + CNT_W'(1);
        same_n  = (pc_valid && pc_in == last_pc) ? same_cnt + SW'(1) : '0;
        err_c   = |pc_in[1:0];
        halt_c  = same_n == SW'(HALT_REPEAT);
        to_c    = cnt_n == CNT_W'(MAX_CYCLES);
        case (state)
            IDLE, DONE: begin
                state_n = start ? HOLD : state;
                restart = start;
            end
            HOLD:    state_n = (hold_cnt == HW'(RST_CYCLES - 1)) ? RUN : HOLD;
            default: state_n = (err_c || halt_c || to_c) ? DONE : RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            core_rst      <= 1'b1;
            running       <= 1'b0;
            done          <= 1'b0;
            halt_detected <= 1'b0;
            timeout       <= 1'b0;
            pc_err        <= 1'b0;
            cycle_count   <= '0;
            last_pc       <= '0;
            same_cnt      <= '0;
            pc_valid      <= 1'b0;
            hold_cnt      <= '0;
        end else begin
            state    <= state_n;
            core_rst <= state_n != RUN;
            running  <= state_n == RUN;
            done     <= state_n == DONE;
            if (restart) begin
                halt_detected <= 1'b0;
                timeout       <= 1'b0;
                pc_err        <= 1'b0;
                cycle_count   <= '0;
                last_pc       <= '0;
                same_cnt      <= '0;
                pc_valid      <= 1'b0;
                hold_cnt      <= '0;
            end else if (state == HOLD) begin
                hold_cnt <= hold_cnt + HW'(1);
            end else if (state == RUN) begin
                cycle_count   <= cnt_n;
                last_pc       <= pc_in;
                pc_valid      <= 1'b1;
                same_cnt      <= same_n;
                pc_err        <= err_c;
                halt_detected <= !err_c && halt_c;
                timeout       <= !err_c && !halt_c && to_c;
            end
        end
    end
endmodule

// File: tb/tb_core_run_monitor.sv
// tb_core_run_monitor: scenario tasks drive PC traces; expected end-of-run results
// are queued when a run is launched and popped when done rises.
module tb_core_run_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pc_in = '0;
    logic        core_rst, running, done, halt_detected, timeout, pc_err;
    logic [15:0] cycle_count;
    logic [31:0] last_pc;

    typedef struct packed {
        logic        halt;
        logic        to;
        logic        err;
        logic [15:0] cc;
        logic [31:0] pc;
    } res_t;

    res_t        sb[$];
    logic [31:0] pc_q[$];
    int          checks = 0;
    int          errors = 0;

    core_run_monitor dut (
        .clk(clk), .rst(rst), .start(start), .pc_in(pc_in),
        .core_rst(core_rst), .running(running), .done(done),
        .halt_detected(halt_detected), .timeout(timeout), .pc_err(pc_err),
        .cycle_count(cycle_count), .last_pc(last_pc)
    );

    always #5 clk = ~clk;

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_body(output bit ok);
        int n = 0;
        while (!running && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (running && !done && n < 200) begin
            if (pc_q.size() != 0) pc_in = pc_q.pop_front();
            @(negedge clk);
            n++;
        end
        ok = done;
    endtask

    function automatic res_t actual();
        return {halt_detected, timeout, pc_err, cycle_count, last_pc};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({core_rst, running, done, cycle_count, last_pc} !== {1'b1, 1'b0, 1'b0, 16'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_state: got core_rst=%b running=%b done=%b cc=%0d last_pc=%h, want 1 0 0 0 0",
                     core_rst, running, done, cycle_count, last_pc);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({core_rst, running, done} !== 3'b100) begin
            errors++;
            $display("FAIL idle_no_start: got core_rst=%b running=%b done=%b, want 1 0 0", core_rst, running, done);
        end
    endtask

    task automatic test_reset_hold;
        logic [1:0] seen[3];
        pulse_start();
        seen[0] = {core_rst, running};
        @(negedge clk); seen[1] = {core_rst, running};
        @(negedge clk); seen[2] = {core_rst, running};
        checks++;
        if ({seen[0], seen[1], seen[2]} !== 6'b10_10_01) begin
            errors++;
            $display("FAIL reset_hold: got {core_rst,running} %b %b %b, want 10 10 01", seen[0], seen[1], seen[2]);
        end
        rst = 1'b1; @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_halt;
        bit ok;
        res_t exp;
        pc_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC};
        sb.push_back('{1'b1, 1'b0, 1'b0, 16'd8, 32'hC});
        pulse_start();
        run_body(ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || actual() !== exp) begin
            errors++;
            $display("FAIL halt: got %h (done=%b), want %h", actual(), done, exp);
        end
        checks++;
        if ({done, core_rst, running} !== 3'b110) begin
            errors++;
            $display("FAIL halt_done_outputs: got done=%b core_rst=%b running=%b, want 1 1 0", done, core_rst, running);
        end
    endtask

    task automatic test_timeout;
        bit ok;
        res_t exp;
        pc_q.delete();
        for (int i = 0; i < 60; i++) pc_q.push_back(32'(i * 4));
        sb.push_back('{1'b0, 1'b1, 1'b0, 16'd50, 32'hC4});
        pulse_start();
        run_body(ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || actual() !== exp) begin
            errors++;
            $display("FAIL timeout: got %h (done=%b), want %h", actual(), done, exp);
        end
    endtask

    task automatic test_misalign;
        bit ok;
        res_t exp;
        pc_q = '{32'h0, 32'h4, 32'h6, 32'h8};
        sb.push_back('{1'b0, 1'b0, 1'b1, 16'd3, 32'h6});
        pulse_start();
        run_body(ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || actual() !== exp) begin
            errors++;
            $display("FAIL misalign: got %h (done=%b), want %h", actual(), done, exp);
        end
    endtask

    task automatic test_priority;
        bit ok;
        res_t exp;
        // halt and timeout coincide on cycle 50: halt wins
        pc_q.delete();
        for (int i = 0; i < 46; i++) pc_q.push_back(32'(i * 4));
        repeat (6) pc_q.push_back(32'hB4);
        sb.push_back('{1'b1, 1'b0, 1'b0, 16'd50, 32'hB4});
        pulse_start();
        run_body(ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || actual() !== exp) begin
            errors++;
            $display("FAIL prio_halt_timeout: got %h (done=%b), want %h", actual(), done, exp);
        end
        // misaligned PC on the timeout cycle: pc_err wins
        pc_q.delete();
        for (int i = 0; i < 49; i++) pc_q.push_back(32'(i * 4));
        pc_q.push_back(32'hC6);
        sb.push_back('{1'b0, 1'b0, 1'b1, 16'd50, 32'hC6});
        pulse_start();
        run_body(ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || actual() !== exp) begin
            errors++;
            $display("FAIL prio_err_timeout: got %h (done=%b), want %h", actual(), done, exp);
        end
        // first RUN cycle never counts as a repeat, even when PC equals the cleared last_pc
        pc_q = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        sb.push_back('{1'b1, 1'b0, 1'b0, 16'd5, 32'h0});
        pulse_start();
        run_body(ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || actual() !== exp) begin
            errors++;
            $display("FAIL first_cycle_no_compare: got %h (done=%b), want %h", actual(), done, exp);
        end
    endtask

    task automatic test_async_reset;
        int n = 0;
        int i = 0;
        pulse_start();
        while (!running && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (cycle_count != 16'd10 && n < 40) begin
            pc_in = 32'(i * 4); i++;
            @(negedge clk); n++;
        end
        checks++;
        if (cycle_count !== 16'd10 || !running) begin
            errors++;
            $display("FAIL async_setup: got cc=%0d running=%b, want 10 1", cycle_count, running);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({core_rst, running, done, cycle_count, last_pc} !== {1'b1, 1'b0, 1'b0, 16'd0, 32'd0}) begin
            errors++;
            $display("FAIL async_reset: got core_rst=%b running=%b done=%b cc=%0d last_pc=%h, want 1 0 0 0 0",
                     core_rst, running, done, cycle_count, last_pc);
        end
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({core_rst, running, done} !== 3'b100) begin
            errors++;
            $display("FAIL async_stays_idle: got core_rst=%b running=%b done=%b, want 1 0 0", core_rst, running, done);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        res_t exp;
        pc_q = '{32'h8, 32'h8, 32'h8, 32'h8, 32'h8, 32'h8};
        sb.push_back('{1'b1, 1'b0, 1'b0, 16'd5, 32'h8});
        pulse_start();
        run_body(ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || actual() !== exp) begin
            errors++;
            $display("FAIL b2b_first: got %h (done=%b), want %h", actual(), done, exp);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (!done || actual() !== exp) begin
            errors++;
            $display("FAIL done_frozen: got %h (done=%b), want %h", actual(), done, exp);
        end
        pc_q = '{32'h10, 32'h13};
        sb.push_back('{1'b0, 1'b0, 1'b1, 16'd2, 32'h13});
        pulse_start();
        checks++;
        if ({done, core_rst, halt_detected, timeout, pc_err, cycle_count, last_pc} !== {5'b01000, 16'd0, 32'd0}) begin
            errors++;
            $display("FAIL restart_clears: got done=%b core_rst=%b flags=%b%b%b cc=%0d last_pc=%h, want 0 1 000 0 0",
                     done, core_rst, halt_detected, timeout, pc_err, cycle_count, last_pc);
        end
        run_body(ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || actual() !== exp) begin
            errors++;
            $display("FAIL b2b_second: got %h (done=%b), want %h", actual(), done, exp);
        end
    endtask

    initial begin
        test_reset();
        test_reset_hold();
        test_halt();
        test_timeout();
        test_misalign();
        test_priority();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
